// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; signed ops iterate on magnitudes.
module muldiv_unit #(
  parameter int NUM_BITS = 32,
  parameter int OP_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OP_BITS-1:0]  md_op,
  input  logic [NUM_BITS-1:0] data1,
  input  logic [NUM_BITS-1:0] data2,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [NUM_BITS-1:0] hi,
  output logic [NUM_BITS-1:0] lo
);

  localparam int CNT_BITS = $clog2(NUM_BITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [OP_BITS-1:0] OP_MULTU = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_MULT  = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_DIVU  = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_DIV   = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_MTHI  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_MTLO  = OP_BITS'(5);

  logic [1:0]            state;
  logic [CNT_BITS-1:0]   count;
  logic [NUM_BITS-1:0]   acc_hi;
  logic [NUM_BITS-1:0]   acc_lo;
  logic [NUM_BITS-1:0]   operand;
  logic                  is_div;
  logic                  neg_main;
  logic                  neg_rem;

  logic                  op_mul;
  logic                  op_div;
  logic                  op_signed;
  logic                  sign1;
  logic                  sign2;
  logic [NUM_BITS-1:0]   mag1;
  logic [NUM_BITS-1:0]   mag2;

  assign op_mul    = (md_op == OP_MULTU) || (md_op == OP_MULT);
  assign op_div    = (md_op == OP_DIVU) || (md_op == OP_DIV);
  assign op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign sign1     = op_signed & data1[NUM_BITS-1];
  assign sign2     = op_signed & data2[NUM_BITS-1];
  assign mag1      = sign1 ? -data1 : data1;
  assign mag2      = sign2 ? -data2 : data2;

  logic [NUM_BITS:0]     mul_sum;
  logic [NUM_BITS:0]     div_shift;
  logic                  div_ge;
  logic [NUM_BITS-1:0]   step_hi;
  logic [NUM_BITS-1:0]   step_lo;
  logic [2*NUM_BITS-1:0] prod;
  logic [2*NUM_BITS-1:0] prod_fixed;
  logic [NUM_BITS-1:0]   fin_hi;
  logic [NUM_BITS-1:0]   fin_lo;

  // acc_hi:acc_lo holds the running product, or remainder:quotient while dividing.
  // The final sign fix-up is taken straight from the last step so the result lands with done.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi, acc_lo[NUM_BITS-1]};
    div_ge    = div_shift >= {1'b0, operand};
    if (is_div) begin
      step_hi = div_ge ? (div_shift[NUM_BITS-1:0] - operand) : div_shift[NUM_BITS-1:0];
      step_lo = {acc_lo[NUM_BITS-2:0], div_ge};
    end else begin
      step_hi = mul_sum[NUM_BITS:1];
      step_lo = {mul_sum[0], acc_lo[NUM_BITS-1:1]};
    end
    prod       = {step_hi, step_lo};
    prod_fixed = neg_main ? -prod : prod;
    if (is_div) begin
      fin_hi = neg_rem ? -step_hi : step_hi;
      fin_lo = neg_main ? -step_lo : step_lo;
    end else begin
      fin_hi = prod_fixed[2*NUM_BITS-1:NUM_BITS];
      fin_lo = prod_fixed[NUM_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand     <= '0;
      is_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count - CNT_BITS'(1);
          if (count == CNT_BITS'(1)) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end
        end
        // FINISH behaves like IDLE so a new request can follow done without a bubble.
        default: begin
          state <= S_IDLE;
          if (start && (op_mul || (op_div && data2 != '0))) begin
            acc_hi   <= '0;
            acc_lo   <= mag1;
            operand  <= mag2;
            is_div   <= op_div;
            neg_main <= sign1 ^ sign2;
            neg_rem  <= sign1;
            count    <= CNT_BITS'(NUM_BITS);
            busy     <= 1'b1;
            state    <= S_RUN;
          end else if (start && op_div) begin
            hi          <= data1;
            lo          <= '1;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            state       <= S_FINISH;
          end else if (start && md_op == OP_MTHI) begin
            hi    <= data1;
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (start && md_op == OP_MTLO) begin
            lo    <= data1;
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared every cycle against a cycle-level arithmetic model.
module tb_muldiv_unit;

  localparam int N       = 32;
  localparam int TIMEOUT = 60;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   md_op = '0;
  logic [N-1:0] data1 = '0;
  logic [N-1:0] data2 = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.NUM_BITS(N), .OP_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .data1(data1), .data2(data2), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: an accepted MULT/DIV completes N edges later with the arithmetic result.
  logic [N-1:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int           m_left = 0;

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd0:    return ua * ub;
      4'd1:    return 64'(sa * sb);
      4'd2:    return {32'(ua % ub), 32'(ua / ub)};
      default: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_pend_hi; m_lo = m_pend_lo; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start) begin
        if (md_op <= 4'd3 && !(md_op >= 4'd2 && data2 == '0)) begin
          {m_pend_hi, m_pend_lo} = ref_result(md_op, data1, data2);
          m_left = N;
          m_busy = 1'b1;
        end else if (md_op == 4'd2 || md_op == 4'd3) begin
          m_hi = data1; m_lo = '1; m_done = 1'b1; m_dbz = 1'b1;
        end else if (md_op == 4'd4) begin
          m_hi = data1; m_done = 1'b1;
        end else if (md_op == 4'd5) begin
          m_lo = data1; m_done = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", N'(busy), N'(m_busy));
      checkOutput("done", N'(done), N'(m_done));
      checkOutput("div_by_zero", N'(div_by_zero), N'(m_dbz));
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
    end
  end

  // Sets the request now; it is sampled at the next rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    md_op = op;
    data1 = a;
    data2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
    end while (!done && cycles < TIMEOUT);
    if (!done) checkOutput("done_timeout", N'(done), N'(1));
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c, b, done_count;
    logic [3:0]   op;
    logic [N-1:0] a, d;

    #7;
    checkOutput("reset_hi", hi, '0);
    checkOutput("reset_lo", lo, '0);
    checkOutput("reset_busy", N'(busy), '0);
    checkOutput("reset_done", N'(done), '0);
    checkOutput("reset_dbz", N'(div_by_zero), '0);
    #5 rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'd1, 32'hFFFF_FFFD, 32'h0000_0005);
    waitDone(c, b);
    checkOutput("mult_latency", N'(c), N'(33));
    checkOutput("mult_busy_cycles", N'(b), N'(32));
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

    applyStimulus(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(c, b);
    checkOutput("b2b_multu_latency", N'(c), N'(33));
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    waitDone(c, b);
    checkOutput("div_neg_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_neg_hi", hi, 32'hFFFF_FFFF);

    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(c, b);
    checkOutput("div_ovf_lo", lo, 32'h8000_0000);
    checkOutput("div_ovf_hi", hi, 32'h0000_0000);
    checkOutput("div_ovf_flag", N'(div_by_zero), '0);

    applyStimulus(4'd2, 32'h0000_0064, 32'h0000_0000);
    waitDone(c, b);
    checkOutput("divz_latency", N'(c), N'(1));
    checkOutput("divz_flag", N'(div_by_zero), N'(1));
    checkOutput("divz_hi", hi, 32'h0000_0064);
    checkOutput("divz_lo", lo, 32'hFFFF_FFFF);

    applyStimulus(4'd5, 32'h1234_5678, 32'h0);
    waitDone(c, b);
    checkOutput("mtlo_latency", N'(c), N'(1));
    checkOutput("mtlo_busy", N'(b), '0);
    checkOutput("mtlo_lo", lo, 32'h1234_5678);

    // Requests and operand changes while busy must be ignored.
    applyStimulus(4'd0, 32'h0000_0003, 32'h0000_0007);
    start = 1'b1; md_op = 4'd4; data1 = 32'hDEAD_BEEF; data2 = 32'h0;
    repeat (5) @(negedge clk);
    checkOutput("busy_ignore_lo", lo, 32'h1234_5678);
    start = 1'b0;
    waitDone(c, b);
    checkOutput("inflight_hi", hi, 32'h0000_0000);
    checkOutput("inflight_lo", lo, 32'h0000_0015);

    applyStimulus(4'd7, 32'hAAAA_AAAA, 32'h5555_5555);
    done_count = 0;
    repeat (3) begin
      @(negedge clk);
      done_count += int'(done);
    end
    checkOutput("nop_done", N'(done_count), '0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 7));
      a  = pick();
      d  = ($urandom_range(0, 4) == 0) ? '0 : pick();
      applyStimulus(op, a, d);
      data1 = $urandom;
      data2 = $urandom;
      md_op = 4'($urandom);
      if (op <= 4'd5) begin
        waitDone(c, b);
        checkOutput("rand_latency", N'(c),
                    (op <= 4'd1 || (op <= 4'd3 && d != '0)) ? N'(33) : N'(1));
      end else begin
        repeat (2) @(negedge clk);
      end
    end

    applyStimulus(4'd1, 32'h0000_1234, 32'hFFFF_0001);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", N'(busy), '0);
    checkOutput("rst_done", N'(done), '0);
    checkOutput("rst_hi", hi, '0);
    checkOutput("rst_lo", lo, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    done_count = 0;
    repeat (40) begin
      @(negedge clk);
      done_count += int'(done);
    end
    checkOutput("post_reset_done", N'(done_count), '0);
    checkOutput("post_reset_hi", hi, '0);
    checkOutput("post_reset_lo", lo, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, operand and HI/LO register width (even, >=8).
REQ-002 SHALL have parameter OP_BITS, default 4, width of md_op.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, request; sampled only when busy=0.
REQ-006 SHALL have port md_op, input, OP_BITS, operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, others NOP.
REQ-007 SHALL have ports data1 and data2, input, NUM_BITS each: multiplicand/dividend and multiplier/divisor; data1 is the MTHI/MTLO source.
REQ-008 SHALL have port busy, output, 1, high while a MULT/DIV iteration is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when hi/lo are updated.
REQ-010 SHALL have port div_by_zero, output, 1, qualifies done for DIV/DIVU with data2=0.
REQ-011 SHALL have ports hi and lo, output, NUM_BITS each: architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE.
REQ-013 SHALL, in IDLE with start=1 and op MULT*/DIV* (divisor nonzero), latch operands, load counter with NUM_BITS, and enter RUN; busy=1 from the next cycle.
REQ-014 SHALL, in RUN, perform one shift-add multiply step or one restoring-divide step per cycle, decrementing the counter, and enter FINISH when the counter reaches 1.
REQ-015 SHALL, in FINISH, write hi/lo, pulse done, drop busy, and return to IDLE; start sampled at edge 0 gives done high in cycle NUM_BITS+1.
REQ-016 SHALL give MULTU/MULT the full 2*NUM_BITS product: {hi,lo}.
REQ-017 SHALL, for MULT, iterate on magnitudes and negate the 2*NUM_BITS result when the operand signs differ.
REQ-018 SHALL give DIVU/DIV the quotient in lo and the remainder in hi.
REQ-019 SHALL, for DIV, make the quotient negative iff the operand signs differ, give the remainder the sign of the dividend, and truncate toward zero.
REQ-020 SHALL, for DIV of the most-negative value by -1, give lo = most-negative value (wrap) and hi = 0 with no flag.
REQ-021 SHALL, for DIV/DIVU with data2=0, skip RUN, set hi=data1 and lo=all ones on the next edge, and pulse done and div_by_zero together.
REQ-022 SHALL, for MTHI/MTLO, write data1 to hi/lo on the next edge with a done pulse and no busy.
REQ-023 SHALL treat start with a NOP opcode as no action and produce no done.
REQ-024 SHALL ignore start, md_op, and data changes while busy=1, so operands are latched at acceptance.
REQ-025 SHALL keep hi/lo unchanged between completions.
REQ-026 SHALL accept a new start in the cycle done is high, since FSM is IDLE-capable that cycle: back-to-back operation with no bubble beyond FINISH.

Reset
REQ-027 SHALL, on rst_n=0 and immediately without clk, force FSM=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, and div_by_zero=0.
REQ-028 SHALL, when reset is asserted mid-RUN, discard the operation with no done, and leave hi/lo at 0 after release.

Verification (NUM_BITS=32)
REQ-029 SHALL cover MULT data1=FFFFFFFD, data2=00000005 -> done in cycle 33, hi=FFFFFFFF, lo=FFFFFFF1, busy high cycles 1-32.
REQ-030 SHALL cover MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-031 SHALL cover DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; and DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
REQ-032 SHALL cover DIVU 00000064 / 0 -> done and div_by_zero in cycle 1, hi=00000064, lo=FFFFFFFF.
REQ-033 SHALL cover MTLO 12345678, then start with a changed data1 while busy -> lo=12345678 after the MTLO, and the in-flight result is unaffected.
REQ-034 SHALL cover rst_n low at RUN cycle 10 -> busy, done, hi, and lo all 0 immediately, no done after release.
